// File: rtl/sd_resp_rx.sv
// ============================================================================
// sd_resp_rx : SD CMD-line response receiver with CRC7 and framing checks.
//              Optional inocrc input under SD_RESP_NOCRC_EN.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_resp_rx #(
    parameter int NCR_MAX = 64
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic         ilong,
`ifdef SD_RESP_NOCRC_EN
    input  logic         inocrc,
`endif
    input  logic         icmd,
    output logic         obusy,
    output logic         odone,
    output logic         otimeout,
    output logic         ocrc_err,
    output logic         ofmt_err,
    output logic [5:0]   oindex,
    output logic [119:0] odata
);

    localparam int WCW = $clog2(NCR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           long_q, long_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [126:0]   sr_q, sr_d;
    logic [6:0]     crc_q, crc_d;
    logic           tx_q, tx_d;
    logic           timeout_q, timeout_d;
    logic           crc_err_q, crc_err_d;
    logic           fmt_err_q, fmt_err_d;
    logic [5:0]     index_q, index_d;
    logic [119:0]   data_q, data_d;

    logic [7:0]     last_bit;
    logic [6:0]     crc_next;
    logic           covered;

`ifdef SD_RESP_NOCRC_EN
    logic nocrc_q, nocrc_d;

    always_ff @(posedge iclk) begin
        if (irst) nocrc_q <= 1'b0;
        else      nocrc_q <= nocrc_d;
    end

    always_comb begin
        nocrc_d = nocrc_q;
        if (state_q == S_IDLE && istart) nocrc_d = inocrc;
    end
`else
    logic nocrc_q;
    assign nocrc_q = 1'b0;
`endif

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q   <= S_IDLE;
            long_q    <= 1'b0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            sr_q      <= '0;
            crc_q     <= '0;
            tx_q      <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            fmt_err_q <= 1'b0;
            index_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            long_q    <= long_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            sr_q      <= sr_d;
            crc_q     <= crc_d;
            tx_q      <= tx_d;
            timeout_q <= timeout_d;
            crc_err_q <= crc_err_d;
            fmt_err_q <= fmt_err_d;
            index_q   <= index_d;
            data_q    <= data_d;
        end
    end

    // bcnt counts bits already taken (start bit = 0); the long header is kept out of the CRC
    assign last_bit = long_q ? 8'd135 : 8'd47;
    assign covered  = (bcnt_q >= (long_q ? 8'd8 : 8'd1)) && (bcnt_q <= last_bit - 8'd8);
    assign crc_next = {crc_q[5:0], 1'b0} ^ ({7{icmd ^ crc_q[6]}} & 7'h09);

    always_comb begin
        state_d   = state_q;
        long_d    = long_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        sr_d      = sr_q;
        crc_d     = crc_q;
        tx_d      = tx_q;
        timeout_d = timeout_q;
        crc_err_d = crc_err_q;
        fmt_err_d = fmt_err_q;
        index_d   = index_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    state_d   = S_WAIT;
                    long_d    = ilong;
                    wcnt_d    = '0;
                    timeout_d = 1'b0;
                    crc_err_d = 1'b0;
                    fmt_err_d = 1'b0;
                    index_d   = '0;
                    data_d    = '0;
                end
            end
            S_WAIT: begin
                if (!icmd) begin
                    state_d = S_RECV;
                    bcnt_d  = 8'd1;
                    crc_d   = '0;
                    sr_d    = '0;
                    tx_d    = 1'b0;
                end else if (wcnt_q == WCW'(NCR_MAX - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_RECV: begin
                bcnt_d = bcnt_q + 8'd1;
                sr_d   = {sr_q[125:0], icmd};
                if (bcnt_q == 8'd1) tx_d = icmd;
                if (covered) crc_d = crc_next;
                // End bit: sr_q holds frame bits [127:1] (long) or [46:1] (short)
                if (bcnt_q == last_bit) begin
                    state_d   = S_DONE;
                    crc_err_d = (crc_q != sr_q[6:0]) && !nocrc_q;
                    fmt_err_d = tx_q || !icmd;
                    index_d   = long_q ? 6'd0 : sr_q[44:39];
                    data_d    = long_q ? sr_q[126:7] : {82'b0, sr_q[44:7]};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign obusy    = (state_q == S_WAIT) || (state_q == S_RECV);
    assign odone    = (state_q == S_DONE);
    assign otimeout = timeout_q;
    assign ocrc_err = crc_err_q;
    assign ofmt_err = fmt_err_q;
    assign oindex   = index_q;
    assign odata    = data_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_resp_rx.sv
// ============================================================================
// tb_sd_resp_rx : directed vector bench for sd_resp_rx.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_resp_rx;

    localparam int NCR_MAX = 64;

    logic         iclk = 1'b0;
    logic         irst, istart, ilong, icmd;
`ifdef SD_RESP_NOCRC_EN
    logic         inocrc = 1'b0;
`endif
    logic         obusy, odone, otimeout, ocrc_err, ofmt_err;
    logic [5:0]   oindex;
    logic [119:0] odata;

    int errors = 0;
    int checks = 0;

    sd_resp_rx #(.NCR_MAX(NCR_MAX)) dut (
        .iclk     (iclk),
        .irst     (irst),
        .istart   (istart),
        .ilong    (ilong),
`ifdef SD_RESP_NOCRC_EN
        .inocrc   (inocrc),
`endif
        .icmd     (icmd),
        .obusy    (obusy),
        .odone    (odone),
        .otimeout (otimeout),
        .ocrc_err (ocrc_err),
        .ofmt_err (ofmt_err),
        .oindex   (oindex),
        .odata    (odata)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic         lng;
        logic [135:0] frame;
        int           gap;
        logic [5:0]   eidx;
        logic [119:0] edata;
        logic         ecrc;
        logic         efmt;
        int           busy_at;
        logic         nocrc;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Polynomial long division by x^7+x^3+1 over the n low bits of m
    function automatic logic [6:0] crc7_f(input logic [119:0] m, input int n);
        logic [126:0] r;
        r = {m, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg,
                                              input logic tx, input logic flip, input logic endb,
                                              input logic force_en, input logic [6:0] force_crc);
        logic [6:0]  c;
        logic [31:0] a;
        c = force_en ? force_crc : crc7_f({80'b0, 1'b0, tx, idx, arg}, 40);
        a = arg ^ {31'b0, flip};
        return {88'b0, 1'b0, tx, idx, a, c, endb};
    endfunction

    function automatic logic [135:0] mk_long(input logic [127:0] cid);
        return {2'b00, 6'h3F, cid[127:8], crc7_f(cid[127:8], 120), 1'b1};
    endfunction

    function automatic vec_t mkv(input logic lng, input logic [135:0] fr, input int gap,
                                 input logic [5:0] eidx, input logic [119:0] edata,
                                 input logic ecrc, input logic efmt, input int busy_at,
                                 input logic nocrc);
        vec_t v;
        v.lng = lng; v.frame = fr; v.gap = gap; v.eidx = eidx; v.edata = edata;
        v.ecrc = ecrc; v.efmt = efmt; v.busy_at = busy_at; v.nocrc = nocrc;
        return v;
    endfunction

    // pre=1: caller already raised istart at the current negedge
    task automatic run_vec(input vec_t v, input int n, input bit pre);
        int   nb;
        logic early;
        nb    = v.lng ? 136 : 48;
        early = 1'b0;
        if (!pre) begin
            @(negedge iclk);
            istart = 1'b1;
            ilong  = v.lng;
`ifdef SD_RESP_NOCRC_EN
            inocrc = v.nocrc;
`endif
        end
        @(negedge iclk);
        istart = 1'b0;
        ilong  = 1'b0;
        chk($sformatf("v%0d busy_after_start", n), {119'b0, obusy}, 120'd1);
        repeat (v.gap) @(negedge iclk);
        for (int i = nb - 1; i >= 0; i--) begin
            icmd   = v.frame[i];
            istart = ((nb - 1 - i) == v.busy_at);
            ilong  = istart ? ~v.lng : 1'b0;
            @(negedge iclk);
            if (i != 0 && odone) early = 1'b1;
        end
        istart = 1'b0;
        ilong  = 1'b0;
        icmd   = 1'b1;
        chk($sformatf("v%0d early_done", n), {119'b0, early}, 120'd0);
        chk($sformatf("v%0d done_latency", n), {119'b0, odone}, 120'd1);
        chk($sformatf("v%0d busy_in_done", n), {119'b0, obusy}, 120'd0);
        chk($sformatf("v%0d timeout", n), {119'b0, otimeout}, 120'd0);
        chk($sformatf("v%0d crc_err", n), {119'b0, ocrc_err}, {119'b0, v.ecrc});
        chk($sformatf("v%0d fmt_err", n), {119'b0, ofmt_err}, {119'b0, v.efmt});
        chk($sformatf("v%0d index", n), {114'b0, oindex}, {114'b0, v.eidx});
        chk($sformatf("v%0d data", n), odata, v.edata);
        @(negedge iclk);
        chk($sformatf("v%0d done_pulse", n), {118'b0, odone, obusy}, 120'd0);
        chk($sformatf("v%0d data_hold", n), odata, v.edata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        logic [135:0]  f;
        logic [127:0]  cid;

        cid = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
        vt.push_back(mkv(1'b0, 136'h1, 5, 6'd0, 120'd0, 1'b0, 1'b0, -1, 1'b0));
        vt.push_back(mkv(1'b0, mk_short(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0), 0,
                         6'd8, {82'b0, 6'd8, 32'h1AA}, 1'b0, 1'b0, -1, 1'b0));
        vt.push_back(mkv(1'b0, mk_short(6'd8, 32'h1AA, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0), 3,
                         6'd8, {82'b0, 6'd8, 32'h1AB}, 1'b1, 1'b0, -1, 1'b0));
        vt.push_back(mkv(1'b0, mk_short(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0), 63,
                         6'd8, {82'b0, 6'd8, 32'h1AA}, 1'b0, 1'b1, -1, 1'b0));
        vt.push_back(mkv(1'b0, mk_short(6'd55, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0), 1,
                         6'd55, {82'b0, 6'd55, 32'hDEADBEEF}, 1'b0, 1'b0, 10, 1'b0));
        vt.push_back(mkv(1'b0, mk_short(6'd17, 32'h0000_0900, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0), 2,
                         6'd17, {82'b0, 6'd17, 32'h0000_0900}, 1'b0, 1'b1, -1, 1'b0));
        vt.push_back(mkv(1'b1, mk_long(cid), 2, 6'd0, cid[127:8], 1'b0, 1'b0, 40, 1'b0));
`ifdef SD_RESP_NOCRC_EN
        vt.push_back(mkv(1'b0, mk_short(6'h3F, 32'h00FF_8000, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7F), 4,
                         6'h3F, {82'b0, 6'h3F, 32'h00FF_8000}, 1'b0, 1'b0, -1, 1'b1));
`endif

        irst = 1'b1; istart = 1'b0; ilong = 1'b0; icmd = 1'b1;
        repeat (3) @(negedge iclk);
        chk("reset_ctl", {116'b0, obusy, odone, otimeout, ocrc_err}, 120'd0);
        chk("reset_data", odata ^ {114'b0, oindex}, 120'd0);
        irst = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i, 1'b0);

        // Timeout: icmd idle high after istart
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        n = 1;
        while (!odone && n < 200) begin
            @(negedge iclk);
            n++;
        end
        chk("timeout_latency", 120'(n), 120'(NCR_MAX + 1));
        chk("timeout_flags", {117'b0, otimeout, ocrc_err, ofmt_err}, 120'b100);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        chk("start_in_done_ignored", {119'b0, obusy}, 120'd0);

        // Reset in the middle of a frame, then start in the reset-release cycle
        f = vt[1].frame;
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        for (int i = 47; i > 27; i--) begin
            icmd = f[i];
            @(negedge iclk);
        end
        chk("pre_reset_busy", {119'b0, obusy}, 120'd1);
        irst = 1'b1;
        @(negedge iclk);
        icmd = 1'b1;
        chk("midrx_reset_ctl", {115'b0, obusy, odone, otimeout, ocrc_err, ofmt_err}, 120'd0);
        chk("midrx_reset_data", odata | {114'b0, oindex}, 120'd0);
        irst   = 1'b0;
        istart = 1'b1;
        ilong  = 1'b0;
`ifdef SD_RESP_NOCRC_EN
        inocrc = 1'b0;
`endif
        run_vec(vt[1], 99, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
